od_line_reader: RTL
===================

// Module: od_line_reader
// PURPOSE
//  Receive-side reader for a single pulled-up, open-drain serial line: remote drivers
//  only pull low, and the weak/pull-up drive returns the line high when released.
//  The reader synchronises and glitch-filters the line, then measures each low pulse.
//  Each pulse is classified as a 1-bit, a 0-bit, a framing error or a bus-reset pulse.
//  Bits are assembled LSB-first into words and delivered over a valid/ready port.
// PARAMETERS
//  DATA_W     8    bits per delivered word
//  FILT_LEN   3    consecutive equal synced samples required to change the filtered level
//  LOW_MIN    4    shortest low width (cycles) accepted as a slot; shorter = glitch
//  BIT1_MAX   15   LOW_MIN <= w <= BIT1_MAX decodes as bit 1
//  BIT0_MAX   60   BIT1_MAX < w <= BIT0_MAX decodes as bit 0
//  RESET_MIN  240  w >= RESET_MIN is a bus-reset pulse
//  CNT_W      10   width counter bits; must hold RESET_MIN
// PORTS
//  clk          in   1       single clock; every flop sits in this domain
//  rst          in   1       asynchronous, active-high reset
//  enable_i     in   1       0 = hold decoder idle and discard any partial word
//  line_i       in   1       raw open-drain line; 1'bz/1'bx are sampled as 1 (pull-up semantics)
//  data_o       out  DATA_W  received word, stable while valid_o=1
//  valid_o      out  1       word available; held until ready_i
//  ready_i      in   1       consumer accepts data_o when valid_o&&ready_i
//  reset_det_o  out  1       one-cycle pulse when a bus-reset pulse is decoded
//  frame_err_o  out  1       one-cycle pulse when BIT0_MAX < w < RESET_MIN
//  overflow_o   out  1       sticky; a completed word was dropped
//  clr_i        in   1       synchronous clear of overflow_o
// BEHAVIOUR
//  Reset values: data_o=0, valid_o=0, reset_det_o=0, frame_err_o=0, overflow_o=0.
//   Internally, sync flops=1, filtered level=1, FSM=IDLE, bit count=0.
//  Input conditioning: line_i is converted to (line_i!==1'b0), passed through 2 sync flops,
//   then through the FILT_LEN filter. Both edges see the same delay, so a clean low pulse
//   keeps its width exactly.
//  FSM: IDLE (filtered level high) -> LOW on filtered falling edge; width counter=1.
//   LOW: counter +1 per cycle, saturating at 2^CNT_W-1; on filtered rising edge -> CLASSIFY.
//   CLASSIFY (1 cycle): act on width w, then -> IDLE.
//  Classification of w:
//   glitch: ignored, no state change.
//   bit: shift into shift register LSB-first and increment bit count.
//   frame error: pulse frame_err_o and clear shift register and bit count.
//   bus reset: pulse reset_det_o and clear shift register and bit count.
//  Word complete (bit count reaches DATA_W):
//   If valid_o=0, or valid_o&&ready_i in the same cycle, load data_o and set valid_o=1.
//   Otherwise drop the word, set overflow_o, and leave data_o unchanged.
//   Bit count returns to 0 in either case.
//  Latency: valid_o rises FILT_LEN+3 clk edges after the first raw-high sample that ends
//   the last bit's low pulse.
//  valid_o clears on the edge where valid_o&&ready_i, unless a new word loads on that edge.
//  clr_i and a new overflow on the same edge: overflow_o ends at 1 (set wins).
//  enable_i=0: FSM forced to IDLE, counter, shift register and bit count cleared.
//   data_o, valid_o and overflow_o are unaffected.
//  rst mid-slot: all state cleared at once; the pulse in progress is lost; no pulse outputs.
//  Filtered line stuck low: counter saturates; on release the pulse classifies as bus reset.
// STRUCTURE
//  Shared package od_reader_pkg: FSM state enum (IDLE, LOW, CLASSIFY); slot class enum
//   (GLITCH, BIT1, BIT0, FRAME_ERR, BUS_RST); width classification function.
//  Sub-module od_line_filter holds the X/Z-to-1 mapping, 2-flop sync and FILT_LEN filter,
//   and outputs the filtered level plus rise/fall strobes.
//  The top level holds the FSM, width counter, shift register and output register.
// TESTING (defaults)
//  1 ready_i=1; send 0xA5 LSB-first (1-bit low=8, 0-bit low=40, 20 high between)
//    -> one valid_o cycle, data_o=8'hA5, no error pulses.
//  2 As 1, plus a 2-cycle low glitch after bit 3 -> data_o=8'hA5, no frame_err_o.
//  3 Send 3 bits, then low=300, then 0x5A -> reset_det_o pulses once; next word 8'h5A.
//  4 ready_i=0; send 0x3C then 0xC3 -> data_o=8'h3C held, valid_o=1, overflow_o=1;
//    then clr_i -> overflow_o=0; ready_i pulse -> valid_o=0.
//  5 line_i=1'bz for 500 cycles -> no output activity; one low of 100 -> frame_err_o pulse.
//  6 Async rst mid-LOW (cycle 20 of a 40-cycle pulse) -> all outputs 0 at once;
//    after release the next clean word 0x81 decodes correctly.

Source files
------------

// File: rtl/od_reader_pkg.sv
// Shared types and width classification for the open-drain line reader.
package od_reader_pkg;

    // Decoder states: waiting for a low, measuring a low, acting on its width
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOW      = 2'd1,
        ST_CLASSIFY = 2'd2
    } state_e;

    // What a measured low pulse means
    typedef enum logic [2:0] {
        SC_GLITCH    = 3'd0,
        SC_BIT1      = 3'd1,
        SC_BIT0      = 3'd2,
        SC_FRAME_ERR = 3'd3,
        SC_BUS_RST   = 3'd4
    } slot_e;

    // Map a low width onto a slot class using the supplied thresholds
    function automatic slot_e classify_width(
        input int unsigned w,
        input int unsigned low_min,
        input int unsigned bit1_max,
        input int unsigned bit0_max,
        input int unsigned reset_min
    );
        slot_e cls;
        if (w < low_min) begin
            cls = SC_GLITCH;
        end else if (w <= bit1_max) begin
            cls = SC_BIT1;
        end else if (w <= bit0_max) begin
            cls = SC_BIT0;
        end else if (w < reset_min) begin
            cls = SC_FRAME_ERR;
        end else begin
            cls = SC_BUS_RST;
        end
        return cls;
    endfunction

endpackage

// File: rtl/od_line_filter.sv
// Input conditioning: undriven line reads as high, two-flop synchroniser,
// then a majority-free run filter that only moves the level after FILT_LEN
// identical synchronised samples. Rise and fall use the same path, so a clean
// low keeps its width.
module od_line_filter
    import od_reader_pkg::*;
#(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic                  line_s;
    logic                  sync1_q;
    logic                  sync2_q;
    logic [FILT_LEN-2:0]   hist_q;
    logic [FILT_LEN-1:0]   window_s;
    logic                  level_q;
    logic                  level_d;

    // Only a solid 0 is a pull-down; Z/X mean the pull-up owns the line
    assign line_s   = (line_i !== 1'b0);
    assign window_s = {hist_q, sync2_q};

    // Filtered level changes only when the whole window agrees
    always_comb begin
        level_d = level_q;
        if (&window_s) begin
            level_d = 1'b1;
        end else if (~|window_s) begin
            level_d = 1'b0;
        end else begin
            level_d = level_q;
        end
    end

    // Synchroniser, sample history and filtered level registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= {(FILT_LEN-1){1'b1}};
            level_q <= 1'b1;
        end else begin
            sync1_q <= line_s;
            sync2_q <= sync1_q;
            hist_q  <= window_s[FILT_LEN-2:0];
            level_q <= level_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = level_d & ~level_q;
    assign fall_o  = ~level_d & level_q;

endmodule

// File: rtl/od_line_reader.sv
// Open-drain line reader: measures filtered low pulses, decodes bits,
// bus resets and framing errors, and delivers LSB-first words over valid/ready.
module od_line_reader
    import od_reader_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int FILT_LEN  = 3,
    parameter int LOW_MIN   = 4,
    parameter int BIT1_MAX  = 15,
    parameter int BIT0_MAX  = 60,
    parameter int RESET_MIN = 240,
    parameter int CNT_W     = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_i,
    input  logic              line_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              reset_det_o,
    output logic              frame_err_o,
    output logic              overflow_o,
    input  logic              clr_i
);

    localparam int BC_W = $clog2(DATA_W + 1);

    logic              level_s;
    logic              rise_s;
    logic              fall_s;
    slot_e             slot_s;
    logic              word_done_s;

    state_e            state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [DATA_W-1:0] shift_q,  shift_d;
    logic [BC_W-1:0]   bitcnt_q, bitcnt_d;
    logic [DATA_W-1:0] data_q,   data_d;
    logic              valid_q,  valid_d;
    logic              ovf_q,    ovf_d;
    logic              rdet_q,   rdet_d;
    logic              ferr_q,   ferr_d;

    od_line_filter #(.FILT_LEN(FILT_LEN)) u_filter (
        .clk     (clk),
        .rst     (rst),
        .line_i  (line_i),
        .level_o (level_s),
        .rise_o  (rise_s),
        .fall_o  (fall_s)
    );

    assign slot_s = classify_width(32'(cnt_q), LOW_MIN, BIT1_MAX, BIT0_MAX, RESET_MIN);

    // Next-state: pulse measurement FSM, bit assembly and output handshake
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        bitcnt_d    = bitcnt_q;
        data_d      = data_q;
        valid_d     = (valid_q && ready_i) ? 1'b0 : valid_q;
        ovf_d       = clr_i ? 1'b0 : ovf_q;
        rdet_d      = 1'b0;
        ferr_d      = 1'b0;
        word_done_s = 1'b0;

        if (!enable_i) begin
            state_d  = ST_IDLE;
            cnt_d    = {CNT_W{1'b0}};
            shift_d  = {DATA_W{1'b0}};
            bitcnt_d = {BC_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fall_s) begin
                        state_d = ST_LOW;
                        cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOW: begin
                    if (rise_s) begin
                        state_d = ST_CLASSIFY;
                    end else if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_CLASSIFY: begin
                    state_d = ST_IDLE;
                    case (slot_s)
                        SC_BIT1, SC_BIT0: begin
                            shift_d = {(slot_s == SC_BIT1), shift_q[DATA_W-1:1]};
                            if (bitcnt_q == BC_W'(DATA_W - 1)) begin
                                bitcnt_d    = {BC_W{1'b0}};
                                word_done_s = 1'b1;
                            end else begin
                                bitcnt_d = bitcnt_q + {{(BC_W-1){1'b0}}, 1'b1};
                            end
                        end
                        SC_FRAME_ERR: begin
                            ferr_d   = 1'b1;
                            shift_d  = {DATA_W{1'b0}};
                            bitcnt_d = {BC_W{1'b0}};
                        end
                        SC_BUS_RST: begin
                            rdet_d   = 1'b1;
                            shift_d  = {DATA_W{1'b0}};
                            bitcnt_d = {BC_W{1'b0}};
                        end
                        default: begin
                            shift_d = shift_q;
                        end
                    endcase
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // A finished word either lands in the output register or is dropped
        if (word_done_s) begin
            if (!valid_q || ready_i) begin
                data_d  = shift_d;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else begin
            data_d = data_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            shift_q  <= {DATA_W{1'b0}};
            bitcnt_q <= {BC_W{1'b0}};
            data_q   <= {DATA_W{1'b0}};
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            rdet_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            rdet_q   <= rdet_d;
            ferr_q   <= ferr_d;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign overflow_o  = ovf_q;
    assign reset_det_o = rdet_q;
    assign frame_err_o = ferr_q;

endmodule
